rpn_sequencer: RTL and testbench
================================

# rpn_sequencer

Token-stream sequencer that drives the RPN operand-stack datapath (`opstack`: `num`/`op`/`x` in, `qtop` out). It accepts number/operator/end/clear tokens over a valid/ready handshake and issues at most one `num` or `op` strobe per cycle. It tracks logical stack depth to reject underflow and overflow, and returns the final top-of-stack value and an error code over a result handshake. It sits between the program/token source and `opstack` and is the only writer of `opstack` controls.

## Interface
- `DEPTH`, 8: capacity of the attached stack in entries; overflow is detected against this value.
- `DW`, `$clog2(DEPTH+1)`: width of the depth counter (derived, not overridden).

Ports (clk, reset first):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  token accepted when `tok_valid & tok_ready` at a rising edge.
- `tok_kind`  in  2  token kind: 0 NUM, 1 OP, 2 END, 3 CLR.
- `tok_data`  in  16  NUM: operand value. OP: function code; `[4]`=1 means unary (no pop), `[4:0]` goes to the ALU.
- `num`  out  1  push strobe to `opstack`.
- `op`  out  1  operate strobe to `opstack`.
- `x`  out  16  data/function to `opstack`.
- `qtop`  in  16  top-of-stack from `opstack`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_data`  out  16  captured top-of-stack; 0 when `res_err`≠0.
- `res_err`  out  2  0 OK, 1 underflow, 2 overflow, 3 bad end depth.
- `depth`  out  DW  current logical stack depth.

## Operation
States: RUN, FLUSH, RESULT.
- **RUN**: `tok_ready`=1. The accepted token, its legality, and its effect:
  - NUM: legal if depth<DEPTH. Drives `num`=1, `x`=tok_data. depth+1.
  - OP binary (`tok_data[4]`=0): legal if depth≥2. Drives `op`=1, `x`=tok_data. depth−1.
  - OP unary (`tok_data[4]`=1): legal if depth≥1. Drives `op`=1. depth unchanged.
  - END: if depth==1, capture `qtop` into `res_data` with err 0, else err 3 and data 0. depth←0, go to RESULT.
  - CLR: depth←0. No strobe. Stay in RUN.
  - Illegal NUM: err←2. Illegal OP: err←1. No strobe, depth unchanged, go to FLUSH.
- **FLUSH**: `tok_ready`=1. NUM/OP tokens are discarded with no strobes. END or CLR sets depth←0 and goes to RESULT with the sticky err; `res_data`=0.
- **RESULT**: `tok_ready`=0, `res_valid`=1. On `res_ready`, clear err and go to RUN.
- `num`/`op`/`x` are combinational from the accepted token and the legality check. They are never both 1. `num`=`op`=0 whenever no token is accepted. `x`=tok_data at all times, and is don't-care to `opstack` when no strobe is active.
- `opstack` has no reset. Stale contents are harmless because legality is judged only on `depth`.

## Timing
- Reset values: state RUN, depth 0, `res_valid` 0, `res_data` 0, `res_err` 0. Combinationally `num`=`op`=0 and `tok_ready`=1 from the cycle after reset.
- Reset asserted in any state returns to RUN at the next edge and drops a pending result.
- Throughput: one token per cycle in RUN/FLUSH. `opstack` updates at the same edge the token is accepted. `qtop` reflects that token from the next cycle.
- END accepted at edge N samples `qtop`, which already includes every token accepted before N. `res_valid`=1 from cycle N+1.
- Result handshake: `res_data`/`res_err` are held stable while `res_valid`=1. After a result is consumed at edge M, `tok_ready`=1 in cycle M+1, so one bubble follows each result.
- `depth` updates at the acceptance edge and saturates nowhere, because illegal tokens never change it.

## Structure
- Package `rpn_pkg`: `tok_kind_t` (NUM/OP/END/CLR), `err_t` (OK/UNDER/OVER/BADEND), `state_t`, and the constant `UNARY_BIT`=4.
- A single module with no sub-module. The legality/next-depth computation is one combinational block. `opstack` is instantiated alongside it by the parent, not inside it.

## Test plan
- Tokens NUM 3, NUM 4, OP add, END → strobes num,num,op on consecutive cycles. Result 7, err 0, depth 0 after END.
- With DEPTH=8, push 8 NUMs then a 9th NUM → 9th gets no `num` strobe and the block enters FLUSH. The following OP tokens produce no strobes. END gives err 2, data 0.
- NUM 5, OP binary → no `op` strobe. END gives err 1.
- NUM 1, NUM 2, END → err 3, data 0. Then CLR, NUM 9, END → result 9, err 0.
- Unary OP (`x[4]`=1) with depth 1 → `op` strobe, depth stays 1. END returns `qtop`.
- Hold `res_ready`=0 for 5 cycles → `tok_ready`=0 and the result stays stable. Assert `reset` mid-expression (depth 3) → depth 0 and `res_valid` 0 next cycle; a fresh NUM 2, END → result 2.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types for the RPN token sequencer.
// Token kinds, error codes and sequencer states.
package rpn_pkg;

  typedef enum logic [1:0] {
    TK_NUM = 2'd0,
    TK_OP  = 2'd1,
    TK_END = 2'd2,
    TK_CLR = 2'd3
  } tok_kind_t;

  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_UNDER  = 2'd1,
    ERR_OVER   = 2'd2,
    ERR_BADEND = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  localparam int UNARY_BIT = 4;

endpackage

// File: rtl/rpn_sequencer.sv
// Token sequencer driving the opstack num/op controls.
// Tracks logical depth and reports result/error per expression.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [1:0]    tok_kind,
  input  logic [15:0]   tok_data,
  output logic          num,
  output logic          op,
  output logic [15:0]   x,
  input  logic [15:0]   qtop,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic [1:0]    res_err,
  output logic [DW-1:0] depth
);

  localparam logic [DW-1:0] MAXD = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  state_t          r_state;
  logic [DW-1:0]   r_depth;
  logic            r_res_valid;
  logic [15:0]     r_res_data;
  err_t            r_res_err;

  tok_kind_t       w_kind;
  logic            w_unary;
  logic            w_acc;
  logic            w_run;
  logic            w_legal;
  logic [DW-1:0]   w_next_depth;

  assign w_kind  = tok_kind_t'(tok_kind);
  assign w_unary = tok_data[UNARY_BIT];
  assign w_run   = (r_state == S_RUN);
  assign w_acc   = tok_valid & tok_ready;

  // Legality is judged on logical depth only, never on opstack contents.
  always_comb begin
    w_legal      = 1'b0;
    w_next_depth = r_depth;
    unique case (w_kind)
      TK_NUM: begin
        w_legal      = (r_depth < MAXD);
        w_next_depth = r_depth + ONE;
      end
      TK_OP: begin
        if (w_unary) begin
          w_legal = (r_depth >= ONE);
        end else begin
          w_legal      = (r_depth >= TWO);
          w_next_depth = r_depth - ONE;
        end
      end
      TK_END, TK_CLR: begin
        w_legal      = 1'b1;
        w_next_depth = '0;
      end
    endcase
  end

  assign tok_ready = (r_state != S_RESULT);
  assign num = w_acc & w_run & w_legal & (w_kind == TK_NUM);
  assign op  = w_acc & w_run & w_legal & (w_kind == TK_OP);
  assign x   = tok_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_depth     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= ERR_OK;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_acc) begin
            unique case (w_kind)
              TK_NUM, TK_OP: begin
                if (w_legal) begin
                  r_depth <= w_next_depth;
                end else begin
                  r_res_err <= (w_kind == TK_NUM) ? ERR_OVER : ERR_UNDER;
                  r_state   <= S_FLUSH;
                end
              end
              TK_END: begin
                r_depth     <= '0;
                r_res_valid <= 1'b1;
                r_state     <= S_RESULT;
                if (r_depth == ONE) begin
                  r_res_data <= qtop;
                  r_res_err  <= ERR_OK;
                end else begin
                  r_res_data <= '0;
                  r_res_err  <= ERR_BADEND;
                end
              end
              TK_CLR: r_depth <= '0;
            endcase
          end
        end
        S_FLUSH: begin
          if (w_acc && (w_kind == TK_END || w_kind == TK_CLR)) begin
            r_depth     <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= ERR_OK;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign depth     = r_depth;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer with an opstack model and reference model.
// Directed token programs with literal result expectations.
module tb_rpn_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [1:0]    tok_kind = 2'd0;
  logic [15:0]   tok_data = 16'h0;
  logic          num;
  logic          op;
  logic [15:0]   x;
  logic [15:0]   qtop = 16'h0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_data;
  logic [1:0]    res_err;
  logic [DW-1:0] depth;

  int checks = 0;
  int failures = 0;

  rpn_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_data(tok_data),
    .num(num), .op(op), .x(x), .qtop(qtop),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [15:0] alu(input logic [4:0] f,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    case (f)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd16:   return 16'h0 - b;
      5'd17:   return b + 16'h1;
      default: return b;
    endcase
  endfunction

  // Attached opstack: no reset, updates on the DUT's strobes.
  logic [15:0] stk [64];
  int sp = 0;
  always @(posedge clk) begin : opstack_model
    if (num) begin
      if (sp < 64) begin
        stk[sp] = x;
        sp++;
      end
    end else if (op) begin
      if (x[4]) begin
        if (sp >= 1) stk[sp-1] = alu(x[4:0], 16'h0, stk[sp-1]);
      end else if (sp >= 2) begin
        stk[sp-2] = alu(x[4:0], stk[sp-2], stk[sp-1]);
        sp--;
      end
    end
    qtop <= (sp > 0) ? stk[sp-1] : 16'h0;
  end

  // Reference: phase 0 running, 1 discarding after error, 2 result held.
  int          m_phase = 0;
  int          m_depth = 0;
  int          m_err   = 0;
  logic [15:0] m_data  = 16'h0;

  always @(posedge clk) begin : ref_model
    int need;
    if (reset) begin
      m_phase = 0; m_depth = 0; m_err = 0; m_data = 16'h0;
    end else if (m_phase == 2) begin
      if (res_ready) begin
        m_phase = 0;
        m_err = 0;
      end
    end else if (tok_valid) begin
      if (m_phase == 0) begin
        case (tok_kind)
          2'd0: begin
            if (m_depth < DEPTH) m_depth++;
            else begin m_err = 2; m_phase = 1; end
          end
          2'd1: begin
            need = tok_data[4] ? 1 : 2;
            if (m_depth >= need) m_depth -= (tok_data[4] ? 0 : 1);
            else begin m_err = 1; m_phase = 1; end
          end
          2'd2: begin
            m_data  = (m_depth == 1) ? qtop : 16'h0;
            m_err   = (m_depth == 1) ? 0 : 3;
            m_depth = 0;
            m_phase = 2;
          end
          default: m_depth = 0;
        endcase
      end else if (tok_kind >= 2'd2) begin
        m_depth = 0;
        m_data  = 16'h0;
        m_phase = 2;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic e_acc;
    if (!reset) begin
      e_acc = tok_valid && (m_phase != 2);
      chk("tok_ready", 32'(tok_ready), 32'(m_phase != 2));
      chk("num", 32'(num),
          32'(e_acc && m_phase == 0 && tok_kind == 2'd0 && m_depth < DEPTH));
      chk("op", 32'(op),
          32'(e_acc && m_phase == 0 && tok_kind == 2'd1 &&
              m_depth >= (tok_data[4] ? 1 : 2)));
      chk("x", 32'(x), 32'(tok_data));
      chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
      chk("depth", 32'(depth), 32'(m_depth));
      if (m_phase == 2) begin
        chk("res_data", 32'(res_data), 32'(m_data));
        chk("res_err", 32'(res_err), 32'(m_err));
      end
    end
  end

  task automatic tok(input logic [1:0] k, input logic [15:0] d);
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_data  = d;
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic result(input string n, input logic [15:0] ed,
                        input logic [1:0] ee);
    int t = 0;
    while (!res_valid && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    if (!res_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout res_valid=0 exp=1", n);
    end else begin
      chk({n, "_data"}, 32'(res_data), 32'(ed));
      chk({n, "_err"}, 32'(res_err), 32'(ee));
      chk({n, "_depth"}, 32'(depth), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_depth", 32'(depth), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_tok_ready", 32'(tok_ready), 1);

    tok(2'd0, 16'd3); tok(2'd0, 16'd4); tok(2'd1, 16'd0);
    tok(2'd2, 16'd0);
    result("add", 16'd7, 2'd0);

    for (int i = 1; i <= 9; i++) tok(2'd0, 16'(i));
    chk("ovf_depth", 32'(depth), 8);
    tok(2'd1, 16'd0); tok(2'd1, 16'd1);
    tok(2'd2, 16'd0);
    result("overflow", 16'd0, 2'd2);

    tok(2'd0, 16'd5); tok(2'd1, 16'd1);
    chk("unf_depth", 32'(depth), 1);
    tok(2'd2, 16'd0);
    result("underflow", 16'd0, 2'd1);

    tok(2'd0, 16'd1); tok(2'd0, 16'd2); tok(2'd2, 16'd0);
    result("badend", 16'd0, 2'd3);
    tok(2'd3, 16'd0); tok(2'd0, 16'd9); tok(2'd2, 16'd0);
    result("clr9", 16'd9, 2'd0);

    tok(2'd0, 16'd6); tok(2'd1, 16'h0010);
    chk("unary_depth", 32'(depth), 1);
    tok(2'd2, 16'd0);
    result("neg", 16'hFFFA, 2'd0);

    tok(2'd0, 16'd10); tok(2'd0, 16'd20); tok(2'd1, 16'd0);
    tok(2'd2, 16'd0);
    tok_valid = 1'b1; tok_kind = 2'd0; tok_data = 16'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", 32'(tok_ready), 0);
      chk("hold_data", 32'(res_data), 30);
    end
    tok_valid = 1'b0;
    result("hold", 16'd30, 2'd0);

    tok(2'd0, 16'd1); tok(2'd0, 16'd2); tok(2'd0, 16'd3);
    chk("mid_depth", 32'(depth), 3);
    pulse_reset();
    chk("mid_rst_depth", 32'(depth), 0);
    chk("mid_rst_valid", 32'(res_valid), 0);
    tok(2'd0, 16'd2); tok(2'd2, 16'd0);
    result("after_rst", 16'd2, 2'd0);

    tok(2'd0, 16'd4); tok(2'd2, 16'd0);
    chk("pend_valid", 32'(res_valid), 1);
    pulse_reset();
    chk("drop_valid", 32'(res_valid), 0);
    chk("drop_ready", 32'(tok_ready), 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
